capture_reg_arbiter: RTL and testbench

//  Round-robin arbiter that shares one WIDTH-bit rising-edge capture register
//  (bank of D flip-flops) between NREQ requesters. Sequences each access:

---
 rtl/capture_reg_arbiter.sv | 121 ++++++++++++
 tb/tb_capture_reg_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/capture_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit capture register among NREQ requesters.
// Each access is one grant cycle (CAPTURE), then HOLD_CYCLES hold cycles, then one IDLE cycle.
module capture_reg_arbiter #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     wdata,
   output logic [NREQ-1:0]           gnt,
   output logic [WIDTH-1:0]          q,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      done,
   output logic                      busy
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_d;
   logic [WIDTH-1:0]  q_d;
   logic [IW-1:0]     owner_d;
   logic              done_d;
   logic              busy_d;
   logic              found;
   logic [IW-1:0]     win;
   int                idx;

   // Scan ptr+1 .. ptr+NREQ with explicit wrap so non-power-of-2 NREQ never indexes past NREQ-1.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt;
      q_d     = q;
      owner_d = owner;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               state_d    = CAPTURE;
               gnt_d[win] = 1'b1;
               owner_d    = win;
               ptr_d      = win;
            end
         end
         CAPTURE: begin
            for (int k = 0; k < NREQ; k++)
               if (owner == IW'(k)) q_d = wdata[k*WIDTH +: WIDTH];
            if (!req[owner]) begin
               state_d = IDLE;
               gnt_d   = '0;
            end else begin
               state_d = HOLD;
               cnt_d   = CW'(HOLD_CYCLES - 1);
               done_d  = (HOLD_CYCLES == 1);
            end
         end
         HOLD: begin
            // done is registered, so it is raised on the edge that brings the counter to zero.
            if (!req[owner] || cnt_q == '0) begin
               state_d = IDLE;
               gnt_d   = '0;
            end else begin
               cnt_d  = cnt_q - CW'(1);
               done_d = (cnt_q == CW'(1));
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NREQ - 1);
         cnt_q   <= '0;
         gnt     <= '0;
         q       <= '0;
         owner   <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt     <= gnt_d;
         q       <= q_d;
         owner   <= owner_d;
         done    <= done_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Directed bench for capture_reg_arbiter: a 4-requester instance plus a 3-requester one for wrap.
module tb_capture_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [7:0]  q;
   logic [1:0]  owner;
   logic        done, busy;

   logic [2:0]  req3;
   logic [23:0] wdata3;
   logic [2:0]  gnt3;
   logic [7:0]  q3;
   logic [1:0]  owner3;
   logic        done3, busy3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   capture_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata),
      .gnt(gnt), .q(q), .owner(owner), .done(done), .busy(busy)
   );

   capture_reg_arbiter #(.NREQ(3), .WIDTH(8), .HOLD_CYCLES(2)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .wdata(wdata3),
      .gnt(gnt3), .q(q3), .owner(owner3), .done(done3), .busy(busy3)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // Invariant monitor: a capture cycle is the first cycle of a grant (grants are always separated by an idle cycle).
   logic       mon_en = 1'b0;
   int         hist = 0;
   logic [3:0] g1, g2;
   logic [7:0] q1;
   always @(negedge clk) begin
      if (!mon_en) begin
         hist = 0;
      end else begin
         if (hist >= 2) begin
            checks++;
            if ($countones(gnt) > 1) begin
               errors++; $display("FAIL onehot0 gnt=%b", gnt);
            end
            checks++;
            if (done && !busy) begin
               errors++; $display("FAIL done_busy done=%b busy=%b", done, busy);
            end
            checks++;
            if (q !== q1 && !(g1 != 4'b0 && g2 == 4'b0)) begin
               errors++; $display("FAIL q_stable got=%h prev=%h", q, q1);
            end
         end
         g2 = g1; g1 = gnt; q1 = q;
         hist++;
      end
   end

   task automatic test_reset();
      rst = 1'b1; req = '0; wdata = '0; req3 = '0; wdata3 = '0;
      tick();
      checks++;
      if ({gnt, q, owner, done, busy} !== 16'h0) begin
         errors++; $display("FAIL reset gnt=%b q=%h owner=%0d done=%b busy=%b", gnt, q, owner, done, busy);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      wdata[2*8 +: 8] = 8'hA5;
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL single_gnt gnt=%b owner=%0d busy=%b done=%b exp 0100/2/1/0", gnt, owner, busy, done);
      end
      tick();
      checks++;
      if (q !== 8'hA5 || done !== 1'b0) begin
         errors++; $display("FAIL single_q q=%h done=%b exp a5/0", q, done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || gnt !== 4'b0100) begin
         errors++; $display("FAIL single_done done=%b gnt=%b exp 1/0100", done, gnt);
      end
      req = '0;
      tick();
      checks++;
      if (busy !== 1'b0 || gnt !== 4'b0 || done !== 1'b0 || q !== 8'hA5) begin
         errors++; $display("FAIL single_idle busy=%b gnt=%b done=%b q=%h exp 0/0000/0/a5", busy, gnt, done, q);
      end
   endtask

   task automatic test_async_reset();
      wdata[0 +: 8] = 8'h3C;
      req = 4'b0001;
      tick(); tick(); tick();
      checks++;
      if (done !== 1'b1 || q !== 8'h3C) begin
         errors++; $display("FAIL pre_reset done=%b q=%h exp 1/3c", done, q);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0 || q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL async_reset gnt=%b q=%h busy=%b done=%b exp all 0", gnt, q, busy, done);
      end
      req = '0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      wdata = 32'h44332211;
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         e = '0; e[n % 4] = 1'b1;
         tick();
         checks++;
         if (gnt !== e || owner !== 2'(n % 4)) begin
            errors++; $display("FAIL rr_gnt n=%0d gnt=%b owner=%0d exp %b", n, gnt, owner, e);
         end
         tick();
         checks++;
         if (q !== 8'(8'h11 * ((n % 4) + 1))) begin
            errors++; $display("FAIL rr_q n=%0d q=%h", n, q);
         end
         tick();
         tick();
         checks++;
         if (gnt !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rr_gap n=%0d gnt=%b busy=%b exp 0000/0", n, gnt, busy);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_wrap();
      logic [2:0] e;
      wdata3 = 24'h730071;
      req3 = 3'b101;
      for (int n = 0; n < 4; n++) begin
         e = (n % 2 == 0) ? 3'b001 : 3'b100;
         tick();
         checks++;
         if (gnt3 !== e) begin
            errors++; $display("FAIL wrap_gnt n=%0d gnt=%b exp %b", n, gnt3, e);
         end
         tick();
         checks++;
         if (q3 !== ((n % 2 == 0) ? 8'h71 : 8'h73)) begin
            errors++; $display("FAIL wrap_q n=%0d q=%h", n, q3);
         end
         tick(); tick();
      end
      req3 = '0;
      tick();
   endtask

   task automatic test_abort();
      wdata[1*8 +: 8] = 8'h5C;
      req = 4'b0010;
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
         errors++; $display("FAIL abort_gnt gnt=%b exp 0010", gnt);
      end
      tick();
      req = 4'b0000;
      tick();
      checks++;
      if (gnt !== 4'b0 || done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_hold gnt=%b done=%b busy=%b exp 0000/0/0", gnt, done, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || q !== 8'h5C) begin
         errors++; $display("FAIL abort_after done=%b q=%h exp 0/5c", done, q);
      end
      wdata[3*8 +: 8] = 8'hE7;
      req = 4'b1000;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         errors++; $display("FAIL abort_cap_gnt gnt=%b exp 1000", gnt);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || q !== 8'hE7) begin
         errors++; $display("FAIL abort_cap gnt=%b busy=%b done=%b q=%h exp 0000/0/0/e7", gnt, busy, done, q);
      end
      tick();
   endtask

   task automatic test_random();
      mon_en = 1'b1;
      for (int c = 0; c < 400; c++) begin
         req   = 4'($urandom_range(0, 15));
         wdata = $urandom;
         tick();
      end
      req = '0;
      tick(); tick(); tick(); tick();
      mon_en = 1'b0;
      checks++;
      if (busy !== 1'b0 || gnt !== 4'b0) begin
         errors++; $display("FAIL random_drain busy=%b gnt=%b exp 0/0000", busy, gnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_async_reset();
      test_round_robin();
      test_wrap();
      test_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
